// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling FIFO holding {pc, instr} pairs; flushes on redirect.
// Optional FETCH_QUEUE_BYPASS_EN gives an empty-queue zero-latency fetch->decode path.
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              pc_f,
  input  logic [31:0]              instr_f,
  input  logic                     valid_f,
  input  logic                     stallD,
  input  logic                     flushD,
  output logic [31:0]              instr_d,
  output logic [31:0]              pc_d,
  output logic [31:0]              pc_plus4_d,
  output logic                     valid_d,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            empty_c;
  logic            push_c;
  logic            pop_c;
  logic            mem_pop_c;

  assign head    = mem[rd_ptr];
  assign empty_c = (count == '0);
  assign full_o  = (count == CW'(DEPTH));
  assign count_o = count;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass_c;

  // Empty queue with a live fetch: show it to decode this cycle; store it only if decode stalls.
  assign bypass_c  = empty_c & valid_f & ~flushD;
  assign pop_c     = valid_d & ~stallD & ~flushD;
  assign push_c    = valid_f & ~full_o & ~flushD & ~(bypass_c & ~stallD);
  assign mem_pop_c = pop_c & ~bypass_c;
`else
  assign pop_c     = valid_d & ~stallD & ~flushD;
  assign push_c    = valid_f & ~full_o & ~flushD;
  assign mem_pop_c = pop_c;
`endif

  // Head presentation; NOP with pc 0 when nothing is available.
  always_comb begin
    valid_d = 1'b0;
    instr_d = NOP;
    pc_d    = 32'h0;
    if (!empty_c) begin
      valid_d = 1'b1;
      instr_d = head.instr;
      pc_d    = head.pc;
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    else if (bypass_c) begin
      valid_d = 1'b1;
      instr_d = instr_f;
      pc_d    = pc_f;
    end
`endif
  end

  assign pc_plus4_d = pc_d + 32'd4;

  // Pointer and occupancy state; flush behaves exactly like reset.
  always_ff @(posedge clk) begin
    if (rst || flushD) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (mem_pop_c) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      case ({push_c, mem_pop_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; entries are only observed once counted.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= '{pc: pc_f, instr: instr_f};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4).
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_f;
  logic [31:0] instr_f;
  logic        valid_f;
  logic        stallD;
  logic        flushD;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic        full_o;
  logic [2:0]  count_o;

  int passed = 0;
  int total  = 0;

  fetch_queue #(.DEPTH(4), .NOP(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .pc_f(pc_f), .instr_f(instr_f), .valid_f(valid_f),
    .stallD(stallD), .flushD(flushD), .instr_d(instr_d), .pc_d(pc_d),
    .pc_plus4_d(pc_plus4_d), .valid_d(valid_d), .full_o(full_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return 32'hC0DE_0000 | {16'h0, pc[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic v, input logic [31:0] pc);
    valid_f = v;
    pc_f    = pc;
    instr_f = ins(pc);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc, input int cnt);
    chk({tag, "_valid"}, 32'(valid_d), 32'd1);
    chk({tag, "_pc"}, pc_d, pc);
    chk({tag, "_instr"}, instr_d, ins(pc));
    chk({tag, "_pc4"}, pc_plus4_d, pc + 32'd4);
    chk({tag, "_count"}, 32'(count_o), 32'(cnt));
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, 32'(valid_d), 32'd0);
    chk({tag, "_instr"}, instr_d, 32'h0000_0013);
    chk({tag, "_pc"}, pc_d, 32'h0);
    chk({tag, "_pc4"}, pc_plus4_d, 32'h4);
    chk({tag, "_count"}, 32'(count_o), 32'd0);
    chk({tag, "_full"}, 32'(full_o), 32'd0);
  endtask

  // Wrap scenario: fetch index driven per cycle (fetch holds while full), then expected head/count.
  int          wrap_drive [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 8, 8};
  int          wrap_head  [17] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6, 7, 7, 8, 8};
  int          wrap_count [17] = '{1, 1, 2, 2, 3, 3, 4, 3, 4, 3, 4, 3, 3, 2, 2, 1, 1};
  logic [31:0] wrap_base = 32'hFFFF_FFDC;

  initial begin
    rst = 1'b1; stallD = 1'b0; flushD = 1'b0;
    fetch(1'b0, 32'h0);

    tick();
    chk_empty("reset");
    rst = 1'b0;

`ifndef FETCH_QUEUE_BYPASS_EN
    // Streaming: one-cycle latency, count stays at 1.
    fetch(1'b1, 32'h0);
    tick(); chk_head("stream0", 32'h0, 1);
    fetch(1'b1, 32'h4);
    tick(); chk_head("stream1", 32'h4, 1);
    fetch(1'b1, 32'h8);
    tick(); chk_head("stream2", 32'h8, 1);
    fetch(1'b0, 32'h0);
    tick(); chk_empty("stream_drain");

    // Fill under stall; fifth fetch dropped.
    stallD = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fetch(1'b1, 32'h20 + 32'(4 * i));
      tick();
      chk_head("fill", 32'h20, (i < 4) ? i + 1 : 4);
      chk("fill_full", 32'(full_o), (i >= 3) ? 32'd1 : 32'd0);
    end
    fetch(1'b0, 32'h0);
    stallD = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk_head("drain", 32'h20 + 32'(4 * i), 4 - i);
      chk("drain_full", 32'(full_o), 32'd0);
    end
    tick(); chk_empty("drain_end");

    // Flush with three entries and a live fetch.
    stallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch(1'b1, 32'h40 + 32'(4 * i));
      tick();
    end
    chk_head("preflush", 32'h40, 3);
    fetch(1'b1, 32'h4C);
    flushD = 1'b1;
    tick(); chk_empty("flush");
    flushD = 1'b0;
    fetch(1'b0, 32'h0);
    stallD = 1'b0;
    tick(); chk_empty("flush_after");

    // Alternating stall through pointer wrap, ending at pc 0xFFFFFFFC.
    for (int c = 0; c < 17; c++) begin
      stallD = (c % 2 == 0);
      if (c < 11) fetch(1'b1, wrap_base + 32'(4 * wrap_drive[c]));
      else        fetch(1'b0, 32'h0);
      tick();
      chk_head("wrap", wrap_base + 32'(4 * wrap_head[c]), wrap_count[c]);
    end
    chk("wrap_last_pc4", pc_plus4_d, 32'h0000_0000);
    stallD = 1'b0;
    tick(); chk_empty("wrap_end");

    // Reset mid-operation discards entries.
    stallD = 1'b1;
    fetch(1'b1, 32'h60);
    tick(); tick();
    chk("prereset_count", 32'(count_o), 32'd2);
    fetch(1'b0, 32'h0);
    rst = 1'b1;
    tick(); chk_empty("midreset");
    rst = 1'b0;
    stallD = 1'b0;
`else
    // Zero-latency bypass on empty queue.
    fetch(1'b1, 32'h100);
    #1;
    chk("byp_valid", 32'(valid_d), 32'd1);
    chk("byp_pc", pc_d, 32'h100);
    chk("byp_instr", instr_d, ins(32'h100));
    tick();
    chk("byp_count0", 32'(count_o), 32'd0);
    fetch(1'b1, 32'h104);
    stallD = 1'b1;
    #1;
    chk("byp_stall_pc", pc_d, 32'h104);
    tick();
    chk("byp_count1", 32'(count_o), 32'd1);
    fetch(1'b0, 32'h0);
    #1;
    chk_head("byp_stored", 32'h104, 1);
    stallD = 1'b0;
    tick(); chk_empty("byp_drain");
    fetch(1'b1, 32'h200);
    flushD = 1'b1;
    #1;
    chk("byp_flush_valid", 32'(valid_d), 32'd0);
    flushD = 1'b0;
    fetch(1'b0, 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
